i2c_arbiter: RTL

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that shares one I2C4BYTES engine between three requesters.
// Each grant runs one timed SETUP / SEND / GAP sequence with the winner's registered lines and data.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; grant and capture happen in this cycle
// SETUP | lines/data stable, enable low, SETUP_CYCLES cycles
// SEND  | enable high, SEND_CYCLES cycles
// GAP   | enable low, GAP_CYCLES cycles; done pulses in the last one
module i2c_arbiter #(
   parameter int unsigned SETUP_CYCLES = 4194304,
   parameter int unsigned SEND_CYCLES  = 12582912,
   parameter int unsigned GAP_CYCLES   = 4194304
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [2:0]  req_i,
   input  logic [5:0]  lines_i,
   input  logic [47:0] data12_i,
   input  logic [47:0] data34_i,
   output logic [2:0]  gnt_o,
   output logic [2:0]  done_o,
   output logic        busy_o,
   output logic        i2c_enable_o,
   output logic [1:0]  i2c_lines_o,
   output logic [15:0] i2c_data12_o,
   output logic [15:0] i2c_data34_o
);

   localparam logic [23:0] SETUP_LD = 24'(SETUP_CYCLES - 1);
   localparam logic [23:0] SEND_LD  = 24'(SEND_CYCLES - 1);
   localparam logic [23:0] GAP_LD   = 24'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SEND, S_GAP} state_e;

   state_e      state_q, state_d;
   logic [23:0] timer_q, timer_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [1:0]  win_q, win_d;
   logic [1:0]  lines_q, lines_d;
   logic [15:0] d12_q, d12_d;
   logic [15:0] d34_q, d34_d;
   logic        en_q, en_d;

   logic [3:0]  req_ext;
   logic [1:0]  o0, o1, o2, pick;
   logic        grant_fire;
   logic [1:0]  sel_lines;
   logic [15:0] sel_d12, sel_d34;

   function automatic logic [2:0] onehot(input logic [1:0] idx);
      case (idx)
         2'd0:    onehot = 3'b001;
         2'd1:    onehot = 3'b010;
         2'd2:    onehot = 3'b100;
         default: onehot = 3'b000;
      endcase
   endfunction

   // Search order last+1, last+2, last+3 (mod 3); the earliest requesting candidate wins.
   always_comb begin
      req_ext = {1'b0, req_i};
      case (ptr_q)
         2'd0:    {o0, o1, o2} = {2'd1, 2'd2, 2'd0};
         2'd1:    {o0, o1, o2} = {2'd2, 2'd0, 2'd1};
         default: {o0, o1, o2} = {2'd0, 2'd1, 2'd2};
      endcase
      pick = o0;
      if (req_ext[o2]) pick = o2;
      if (req_ext[o1]) pick = o1;
      if (req_ext[o0]) pick = o0;
      grant_fire = (state_q == S_IDLE) && (|req_i);
   end

   always_comb begin
      case (pick)
         2'd1: begin
            sel_lines = lines_i[3:2];
            sel_d12   = data12_i[31:16];
            sel_d34   = data34_i[31:16];
         end
         2'd2: begin
            sel_lines = lines_i[5:4];
            sel_d12   = data12_i[47:32];
            sel_d34   = data34_i[47:32];
         end
         default: begin
            sel_lines = lines_i[1:0];
            sel_d12   = data12_i[15:0];
            sel_d34   = data34_i[15:0];
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         ptr_q   <= 2'd2;
         win_q   <= '0;
         lines_q <= '0;
         d12_q   <= '0;
         d34_q   <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         lines_q <= lines_d;
         d12_q   <= d12_d;
         d34_q   <= d34_d;
         en_q    <= en_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      lines_d = lines_q;
      d12_d   = d12_q;
      d34_d   = d34_q;
      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (grant_fire) begin
               state_d = S_SETUP;
               timer_d = SETUP_LD;
               ptr_d   = pick;
               win_d   = pick;
               lines_d = sel_lines;
               d12_d   = sel_d12;
               d34_d   = sel_d34;
            end
         end
         S_SETUP: begin
            if (timer_q == '0) begin
               state_d = S_SEND;
               timer_d = SEND_LD;
            end else begin
               timer_d = timer_q - 24'd1;
            end
         end
         S_SEND: begin
            if (timer_q == '0) begin
               state_d = S_GAP;
               timer_d = GAP_LD;
            end else begin
               timer_d = timer_q - 24'd1;
            end
         end
         default: begin
            if (timer_q == '0) begin
               state_d = S_IDLE;
               timer_d = '0;
            end else begin
               timer_d = timer_q - 24'd1;
            end
         end
      endcase
      // Enable is registered from the next state so it is high exactly in SEND cycles.
      en_d = (state_d == S_SEND);
   end

   always_comb begin
      gnt_o  = (grant_fire && rst_ni) ? onehot(pick) : 3'b000;
      done_o = (state_q == S_GAP && timer_q == '0) ? onehot(win_q) : 3'b000;
      busy_o = (state_q != S_IDLE);
   end

   assign i2c_enable_o = en_q;
   assign i2c_lines_o  = lines_q;
   assign i2c_data12_o = d12_q;
   assign i2c_data34_o = d34_q;

endmodule
